// File: rtl/shift_register_pkg.sv
// Shared encodings for the universal shift register: operation modes and burst FSM states.
package shift_register_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        LOAD = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        ROL  = 3'd4,
        ROR  = 3'd5,
        ASR  = 3'd6,
        RSVD = 3'd7
    } modeE;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } stateE;

    function automatic logic isShiftMode(logic [2:0] mode);
        return (mode >= 3'(SHL)) && (mode <= 3'(ASR));
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-position next-value function of the shift register; purely combinational.
module shift_step
    import shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             serInL,
    input  logic             serInR,
    output logic [WIDTH-1:0] qNext
);

    always_comb begin
        qNext = q;
        case (mode)
            3'(SHL): qNext = {q[WIDTH-2:0], serInR};
            3'(SHR): qNext = {serInL, q[WIDTH-1:1]};
            3'(ROL): qNext = {q[WIDTH-2:0], q[WIDTH-1]};
            3'(ROR): qNext = {q[0], q[WIDTH-1:1]};
            3'(ASR): qNext = {q[WIDTH-1], q[WIDTH-1:1]};
            default: qNext = q;
        endcase
    end

endmodule

// File: rtl/shift_register_univ.sv
// Universal shift register: parallel load, shifts, rotates and counted bursts with Busy/Done.
module shift_register_univ
    import shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             ResetB,
    input  logic             Start,
    input  logic [2:0]       Mode,
    input  logic [CNT_W-1:0] Count,
    input  logic [WIDTH-1:0] D,
    input  logic             SerInL,
    input  logic             SerInR,
    output logic [WIDTH-1:0] Q,
    output logic             SerOutL,
    output logic             SerOutR,
    output logic             Busy,
    output logic             Done
);

    stateE            stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic [2:0]       modeQ, modeD;
    logic [WIDTH-1:0] qQ, qD;
    logic             doneQ, doneD;

    logic [WIDTH-1:0] shiftNext;
    logic [CNT_W-1:0] countClamped;
    logic             launchBurst;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .q      (qQ),
        .mode   (modeQ),
        .serInL (SerInL),
        .serInR (SerInR),
        .qNext  (shiftNext)
    );

    assign countClamped = (Count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : Count;
    assign launchBurst  = Start && isShiftMode(Mode) && (Count != '0);

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        modeD  = modeQ;
        qD     = qQ;
        doneD  = 1'b0;
        unique case (stateQ)
            IDLE: begin
                if (launchBurst) begin
                    stateD = SHIFT;
                    modeD  = Mode;
                    cntD   = countClamped;
                end else if (Start) begin
                    doneD = 1'b1;
                    if (Mode == 3'(LOAD)) begin
                        qD = D;
                    end
                end
            end
            SHIFT: begin
                qD   = shiftNext;
                cntD = cntQ - CNT_W'(1);
                if (cntQ == CNT_W'(1)) begin
                    doneD  = 1'b1;
                    stateD = IDLE;
                    // Only a new burst may chain on the final shift edge; a LOAD here would
                    // collide with the last shift, so non-burst Starts are ignored until idle.
                    if (launchBurst) begin
                        stateD = SHIFT;
                        modeD  = Mode;
                        cntD   = countClamped;
                    end
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetB) begin
        if (!ResetB) begin
            stateQ <= IDLE;
            cntQ   <= '0;
            modeQ  <= 3'(HOLD);
            qQ     <= '0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            modeQ  <= modeD;
            qQ     <= qD;
            doneQ  <= doneD;
        end
    end

    assign Q       = qQ;
    assign SerOutL = qQ[WIDTH-1];
    assign SerOutR = qQ[0];
    assign Busy    = (stateQ == SHIFT);
    assign Done    = doneQ;

endmodule

// File: tb/tb_shift_register_univ.sv
// Randomised self-checking bench for shift_register_univ against an arithmetic reference model.
module tb_shift_register_univ;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          Clk = 1'b0;
    logic          ResetB;
    logic          Start;
    logic [2:0]    Mode;
    logic [CW-1:0] Count;
    logic [W-1:0]  D;
    logic          SerInL;
    logic          SerInR;
    logic [W-1:0]  Q;
    logic          SerOutL;
    logic          SerOutR;
    logic          Busy;
    logic          Done;

    int total = 0;
    int bad   = 0;
    int expQ;
    bit chainPending = 1'b0;
    bit useFixed     = 1'b0;
    bit fixL, fixR;

    shift_register_univ #(
        .WIDTH (W)
    ) dut (
        .Clk     (Clk),
        .ResetB  (ResetB),
        .Start   (Start),
        .Mode    (Mode),
        .Count   (Count),
        .D       (D),
        .SerInL  (SerInL),
        .SerInR  (SerInR),
        .Q       (Q),
        .SerOutL (SerOutL),
        .SerOutR (SerOutR),
        .Busy    (Busy),
        .Done    (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int refStep(int q, int m, int sl, int sr);
        int msk = (1 << W) - 1;
        case (m)
            2:       return ((q << 1) | sr) & msk;
            3:       return (q >> 1) | (sl << (W - 1));
            4:       return ((q << 1) | (q >> (W - 1))) & msk;
            5:       return (q >> 1) | ((q & 1) << (W - 1));
            6:       return (q >> 1) | (q & (1 << (W - 1)));
            default: return q;
        endcase
    endfunction

    function automatic bit isBurst(int m, int c);
        return (m >= 2) && (m <= 6) && (c != 0);
    endfunction

    task automatic checkOutputs(string tag, int expBusy, int expDone);
        check({tag, ".q"}, 32'(Q), 32'(expQ));
        check({tag, ".busy"}, 32'(Busy), 32'(expBusy));
        check({tag, ".done"}, 32'(Done), 32'(expDone));
        check({tag, ".serl"}, 32'(SerOutL), 32'((expQ >> (W - 1)) & 1));
        check({tag, ".serr"}, 32'(SerOutR), 32'(expQ & 1));
    endtask

    task automatic driveSerial();
        SerInL = useFixed ? fixL : 1'($urandom);
        SerInR = useFixed ? fixR : 1'($urandom);
    endtask

    // One operation from its Start edge through the cycle after Done (or into a chained burst).
    task automatic runOp(int m, int c, int d, bit poke, bit chainNext, int cm, int cc);
        int n;
        if (!chainPending) begin
            @(negedge Clk);
            Start = 1'b1;
            Mode  = 3'(m);
            Count = CW'(c);
            D     = W'(d);
            driveSerial();
            @(posedge Clk);
            #1;
            Start = 1'b0;
            if (!isBurst(m, c)) begin
                if (m == 1) expQ = d & ((1 << W) - 1);
                checkOutputs("inplace0", 0, 1);
                @(posedge Clk);
                #1;
                checkOutputs("inplace1", 0, 0);
                return;
            end
            checkOutputs("edge0", 1, 0);
        end
        chainPending = 1'b0;
        n = (c > W) ? W : c;
        for (int k = 1; k <= n; k++) begin
            @(negedge Clk);
            driveSerial();
            Mode  = 3'($urandom);
            Count = CW'($urandom);
            D     = W'($urandom);
            Start = (poke && k < n) ? 1'($urandom) : 1'b0;
            if (k == n && chainNext) begin
                Start = 1'b1;
                Mode  = 3'(cm);
                Count = CW'(cc);
            end
            @(posedge Clk);
            #1;
            expQ  = refStep(expQ, m, int'(SerInL), int'(SerInR));
            Start = 1'b0;
            checkOutputs("shift", ((k < n) || chainNext) ? 1 : 0, (k == n) ? 1 : 0);
        end
        if (chainNext) begin
            chainPending = 1'b1;
            return;
        end
        @(posedge Clk);
        #1;
        checkOutputs("after", 0, 0);
    endtask

    initial begin
        int m, c, cm, cc;
        bit ch;
        ResetB = 1'b0;
        Start  = 1'b0;
        Mode   = '0;
        Count  = '0;
        D      = '0;
        SerInL = 1'b0;
        SerInR = 1'b0;
        expQ   = 0;
        repeat (2) @(posedge Clk);
        #1;
        checkOutputs("reset", 0, 0);
        @(negedge Clk);
        ResetB = 1'b1;

        runOp(1, 0, 'hA5, 0, 0, 0, 0);
        check("load_a5", 32'(Q), 32'hA5);

        useFixed = 1'b1;
        fixL     = 1'b0;
        fixR     = 1'b1;
        runOp(2, 3, 0, 0, 0, 0, 0);
        check("shl3", 32'(Q), 32'h2F);
        check("shl3_serl", 32'(SerOutL), 32'h0);

        runOp(1, 0, 'hA5, 0, 0, 0, 0);
        runOp(5, 4, 0, 0, 0, 0, 0);
        check("ror4", 32'(Q), 32'h5A);

        runOp(1, 0, 'h90, 0, 0, 0, 0);
        runOp(6, 2, 0, 0, 0, 0, 0);
        check("asr2", 32'(Q), 32'hE4);

        runOp(1, 0, 'hFF, 0, 0, 0, 0);
        runOp(3, 12, 0, 0, 0, 0, 0);
        check("shr_clamp", 32'(Q), 32'h00);
        useFixed = 1'b0;

        runOp(1, 0, 'h3C, 0, 0, 0, 0);
        runOp(4, 5, 0, 1, 1, 2, 2);
        runOp(2, 2, 0, 0, 0, 0, 0);

        // Abort an SHL burst after its second shift; no Done may follow.
        @(negedge Clk);
        Start = 1'b1;
        Mode  = 3'd2;
        Count = CW'(6);
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        ResetB = 1'b0;
        #1;
        expQ = 0;
        checkOutputs("rst_mid", 0, 0);
        repeat (3) begin
            @(posedge Clk);
            #1;
            checkOutputs("rst_hold", 0, 0);
        end
        @(negedge Clk);
        ResetB = 1'b1;
        runOp(2, 0, 0, 0, 0, 0, 0);

        ch = 1'b0;
        cm = 0;
        cc = 0;
        for (int i = 0; i < 40; i++) begin
            if (ch) begin
                m = cm;
                c = cc;
            end else begin
                m = int'($urandom_range(0, 7));
                c = int'($urandom_range(0, 15));
            end
            ch = isBurst(m, c) && ($urandom_range(0, 3) == 0) && (i < 39);
            cm = int'($urandom_range(2, 6));
            cc = int'($urandom_range(1, 15));
            runOp(m, c, int'($urandom), 1'($urandom), ch, cm, cc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
